ring_counter_gen: RTL and testbench

- Parametrised successor to the fixed 8-bit ring counter.
- Width-generic; runtime-selectable ring (one-hot) or Johnson (twisted-ring) mode; bidirectional shift; step enable.
- Provides registered position index and wrap pulse for downstream sequencing (strobe generation, phase selection).
- Drop-in where a one-hot/thermometer sequencer is needed.

---
 rtl/ring_counter_pkg.sv | 30 +++
 rtl/ring_state_check.sv | 37 +++
 rtl/ring_counter_gen.sv | 147 ++++++++++++++
 tb/tb_ring_counter_gen.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/ring_counter_pkg.sv
// Shared constants and helpers for the ring/Johnson sequencer.
// Optional build macro used by the sequencer: RING_COUNTER_GEN_SELF_CORRECT_EN.
package ring_counter_pkg;

  localparam logic MODE_RING    = 1'b0;
  localparam logic MODE_JOHNSON = 1'b1;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

  // Widest counter the start-pattern helper can describe.
  localparam int MAX_WIDTH = 256;

  // Number of distinct states visited before the pattern repeats.
  function automatic int period(input int width, input logic mode);
    return (mode == MODE_JOHNSON) ? 2 * width : width;
  endfunction

  // Pattern loaded on reset/init: MSB-only for ring, all-zero for Johnson.
  // Callers truncate the result to their own width.
  function automatic logic [MAX_WIDTH-1:0] start_pattern(input int width, input logic mode);
    logic [MAX_WIDTH-1:0] p;
    p = '0;
    if (mode == MODE_RING) begin
      p = {{(MAX_WIDTH-1){1'b0}}, 1'b1} << (width - 1);
    end
    return p;
  endfunction

endpackage

// File: rtl/ring_state_check.sv
// Combinational legality check of the counter state for the current mode.
// Ring: exactly one bit set. Johnson: at most one adjacent-bit transition.
module ring_state_check
  import ring_counter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] out,
  input  logic             mode_q,
  output logic             illegal
);

  int ones;
  int edges;

  // Count set bits and non-circular adjacent transitions, then judge by mode.
  always_comb begin
    ones  = 0;
    edges = 0;
    for (int i = 0; i < WIDTH; i++) begin
      if (out[i]) begin
        ones = ones + 1;
      end
    end
    for (int i = 0; i < WIDTH - 1; i++) begin
      if (out[i] != out[i+1]) begin
        edges = edges + 1;
      end
    end
    if (mode_q == MODE_JOHNSON) begin
      illegal = (edges > 1);
    end else begin
      illegal = (ones != 1);
    end
  end

endmodule

// File: rtl/ring_counter_gen.sv
// Width-generic ring / Johnson sequencer with bidirectional step, registered
// position index and wrap pulse.
// Optional build macro: RING_COUNTER_GEN_SELF_CORRECT_EN adds an illegal-state
// checker that reloads the start pattern and raises a sticky err flag.
module ring_counter_gen
  import ring_counter_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit RESET_MODE = 1'b0,
  parameter int POS_W      = $clog2(2 * WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             init,
  input  logic             enable,
  input  logic             mode,
  input  logic             dir,
  output logic [WIDTH-1:0] out,
  output logic [POS_W-1:0] pos,
  output logic             wrap,
  output logic             err
);

  if (WIDTH < 2 || WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("ring_counter_gen: WIDTH out of supported range");
  end

  localparam logic [WIDTH-1:0] START_RESET = WIDTH'(start_pattern(WIDTH, RESET_MODE));

  logic             mode_q, mode_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             wrap_q, wrap_d;

  logic [WIDTH-1:0] out_step;
  logic [POS_W-1:0] pos_step;
  logic [POS_W-1:0] pos_last;
  logic [WIDTH-1:0] start_init;
  logic [WIDTH-1:0] start_cur;
  logic             illegal;

  // Start patterns for an init (new mode) and for a self-correction (held mode).
  always_comb begin
    start_init = WIDTH'(start_pattern(WIDTH, mode));
    start_cur  = WIDTH'(start_pattern(WIDTH, mode_q));
  end

  // One step in the selected direction; pos wraps explicitly at 0 and P-1
  // because P need not be a power of two.
  always_comb begin
    pos_last = POS_W'(period(WIDTH, mode_q) - 1);
    out_step = out_q;
    pos_step = pos_q;
    if (dir == DIR_LEFT) begin
      if (mode_q == MODE_JOHNSON) begin
        out_step = {out_q[WIDTH-2:0], ~out_q[WIDTH-1]};
      end else begin
        out_step = {out_q[WIDTH-2:0], out_q[WIDTH-1]};
      end
      pos_step = (pos_q == '0) ? pos_last : pos_q - 1'b1;
    end else begin
      if (mode_q == MODE_JOHNSON) begin
        out_step = {~out_q[0], out_q[WIDTH-1:1]};
      end else begin
        out_step = {out_q[0], out_q[WIDTH-1:1]};
      end
      pos_step = (pos_q == pos_last) ? '0 : pos_q + 1'b1;
    end
  end

  // Next state with priority init > self-correction > step > hold.
  always_comb begin
    mode_d = mode_q;
    out_d  = out_q;
    pos_d  = pos_q;
    wrap_d = 1'b0;
    if (init) begin
      mode_d = mode;
      out_d  = start_init;
      pos_d  = '0;
    end else if (illegal) begin
      out_d = start_cur;
      pos_d = '0;
    end else if (enable) begin
      out_d  = out_step;
      pos_d  = pos_step;
      wrap_d = (pos_step == '0);
    end
  end

  // Sequencer state register; reset loads the RESET_MODE start pattern.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mode_q <= RESET_MODE;
      out_q  <= START_RESET;
      pos_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      mode_q <= mode_d;
      out_q  <= out_d;
      pos_q  <= pos_d;
      wrap_q <= wrap_d;
    end
  end

`ifdef RING_COUNTER_GEN_SELF_CORRECT_EN
  logic err_q, err_d;

  ring_state_check #(
    .WIDTH(WIDTH)
  ) u_check (
    .out    (out_q),
    .mode_q (mode_q),
    .illegal(illegal)
  );

  // Sticky error: set on any correction, cleared only by init or reset.
  always_comb begin
    err_d = err_q;
    if (init) begin
      err_d = 1'b0;
    end else if (illegal) begin
      err_d = 1'b1;
    end
  end

  // Error flag register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  // No checker: illegal patterns simply circulate.
  assign illegal = 1'b0;
  assign err     = 1'b0;
`endif

  assign out  = out_q;
  assign pos  = pos_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_ring_counter_gen.sv
// Directed, table-driven bench for ring_counter_gen (WIDTH=8, RESET_MODE=0).
module tb_ring_counter_gen;

  logic       clock;
  logic       reset;
  logic       init;
  logic       enable;
  logic       mode;
  logic       dir;
  logic [7:0] out;
  logic [3:0] pos;
  logic       wrap;
  logic       err;

  int checks;
  int errors;

  typedef struct {
    string      name;
    logic       init;
    logic       enable;
    logic       mode;
    logic       dir;
    logic [7:0] exp_out;
    logic [3:0] exp_pos;
    logic       exp_wrap;
  } vec_t;

  vec_t vecs[$];

  ring_counter_gen dut (
    .clock (clock),
    .reset (reset),
    .init  (init),
    .enable(enable),
    .mode  (mode),
    .dir   (dir),
    .out   (out),
    .pos   (pos),
    .wrap  (wrap),
    .err   (err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void add(input string n, input logic i, input logic e, input logic m,
                              input logic d, input logic [7:0] o, input logic [3:0] p,
                              input logic w);
    vec_t v;
    v.name = n; v.init = i; v.enable = e; v.mode = m; v.dir = d;
    v.exp_out = o; v.exp_pos = p; v.exp_wrap = w;
    vecs.push_back(v);
  endfunction

  task automatic apply(input vec_t v);
    @(negedge clock);
    init = v.init; enable = v.enable; mode = v.mode; dir = v.dir;
    @(posedge clock);
    #1;
    check({v.name, ".out"},  32'(out),  32'(v.exp_out));
    check({v.name, ".pos"},  32'(pos),  32'(v.exp_pos));
    check({v.name, ".wrap"}, 32'(wrap), 32'(v.exp_wrap));
    check({v.name, ".err"},  32'(err),  32'd0);
  endtask

  initial begin
    logic [7:0] ones;
    checks = 0;
    errors = 0;
    ones   = 8'hFF;

    // Ring right: 8 steps back to the start pattern, wrap on the 8th.
    for (int k = 1; k <= 8; k++) begin
      add($sformatf("ring_r%0d", k), 1'b0, 1'b1, 1'b0, 1'b0,
          8'h80 >> (k % 8), 4'(k % 8), (k == 8));
    end
    // Hold for 5 cycles: frozen, wrap drops.
    for (int k = 0; k < 5; k++) begin
      add($sformatf("hold%0d", k), 1'b0, 1'b0, 1'b0, 1'b0, 8'h80, 4'd0, 1'b0);
    end
    // Mode toggled without init: ignored while holding and while stepping.
    add("mode_nohold", 1'b0, 1'b0, 1'b1, 1'b0, 8'h80, 4'd0, 1'b0);
    add("mode_nostep", 1'b0, 1'b1, 1'b1, 1'b0, 8'h40, 4'd1, 1'b0);
    // Init with enable low loads the Johnson start pattern.
    add("init_j", 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0);
    // Johnson right: 16 steps, wrap on the 16th.
    for (int k = 1; k <= 16; k++) begin
      add($sformatf("john_r%0d", k), 1'b0, 1'b1, 1'b0, 1'b0,
          (k <= 8) ? ~(ones >> k) : (ones >> (k - 8)), 4'(k % 16), (k == 16));
    end
    // Ring direction reversal around position 0.
    add("init_r",  1'b1, 1'b1, 1'b0, 1'b1, 8'h80, 4'd0, 1'b0);
    add("rev_r1",  1'b0, 1'b1, 1'b0, 1'b0, 8'h40, 4'd1, 1'b0);
    add("rev_r2",  1'b0, 1'b1, 1'b0, 1'b0, 8'h20, 4'd2, 1'b0);
    add("rev_l1",  1'b0, 1'b1, 1'b0, 1'b1, 8'h40, 4'd1, 1'b0);
    add("rev_l2",  1'b0, 1'b1, 1'b0, 1'b1, 8'h80, 4'd0, 1'b1);
    add("rev_l3",  1'b0, 1'b1, 1'b0, 1'b1, 8'h01, 4'd7, 1'b0);
    add("rev_l4",  1'b0, 1'b1, 1'b0, 1'b1, 8'h02, 4'd6, 1'b0);
    add("rev_r3",  1'b0, 1'b1, 1'b0, 1'b0, 8'h01, 4'd7, 1'b0);
    // Johnson left from start, then back right through position 0.
    add("init_j2", 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 4'd0, 1'b0);
    add("john_l1", 1'b0, 1'b1, 1'b1, 1'b1, 8'h01, 4'd15, 1'b0);
    add("john_l2", 1'b0, 1'b1, 1'b1, 1'b1, 8'h03, 4'd14, 1'b0);
    add("john_r1", 1'b0, 1'b1, 1'b1, 1'b0, 8'h01, 4'd15, 1'b0);
    add("john_r2", 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 1'b1);

    // Reset state.
    reset = 1'b1; init = 1'b0; enable = 1'b0; mode = 1'b0; dir = 1'b0;
    #12;
    check("rst.out",  32'(out),  32'h80);
    check("rst.pos",  32'(pos),  32'd0);
    check("rst.wrap", 32'(wrap), 32'd0);
    check("rst.err",  32'(err),  32'd0);
    @(negedge clock);
    reset = 1'b0;

    foreach (vecs[i]) apply(vecs[i]);

    // Async reset between edges while Johnson at 11100000.
    @(negedge clock);
    init = 1'b1; mode = 1'b1; enable = 1'b0; dir = 1'b0;
    @(negedge clock);
    init = 1'b0; enable = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("areset.pre_out", 32'(out), 32'hE0);
    check("areset.pre_pos", 32'(pos), 32'd3);
    #1;
    enable = 1'b0;
    reset  = 1'b1;
    #1;
    check("areset.out",  32'(out),  32'h80);
    check("areset.pos",  32'(pos),  32'd0);
    check("areset.wrap", 32'(wrap), 32'd0);
    @(negedge clock);
    reset = 1'b0;

    // Illegal ring pattern planted into the state register.
    @(negedge clock);
    force dut.out_q = 8'h60;
    #1;
    release dut.out_q;
    enable = 1'b1; dir = 1'b0; mode = 1'b0;
    @(posedge clock);
    #1;
`ifdef RING_COUNTER_GEN_SELF_CORRECT_EN
    check("fix.out", 32'(out), 32'h80);
    check("fix.pos", 32'(pos), 32'd0);
    check("fix.err", 32'(err), 32'd1);
    @(posedge clock);
    #1;
    check("fix_step.out", 32'(out), 32'h40);
    check("fix_step.pos", 32'(pos), 32'd1);
    check("fix_step.err", 32'(err), 32'd1);
    @(negedge clock);
    init = 1'b1; enable = 1'b0;
    @(posedge clock);
    #1;
    check("fix_init.out", 32'(out), 32'h80);
    check("fix_init.err", 32'(err), 32'd0);
`else
    check("nofix.out", 32'(out), 32'h30);
    check("nofix.pos", 32'(pos), 32'd1);
    check("nofix.err", 32'(err), 32'd0);
    @(posedge clock);
    #1;
    check("nofix2.out", 32'(out), 32'h18);
    check("nofix2.err", 32'(err), 32'd0);
`endif
    @(negedge clock);
    init = 1'b0; enable = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
